// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered EX ALU control decoder with MUL/DIV sequencing; in: clk reset flush in_valid alu_op func branch_info jxx; out: out_ctrl out_valid stall mc_busy mc_count
module alu_ctrl_seq #(
  parameter int CTRL_W = 6,
  parameter logic [CTRL_W-1:0] MUL_CODE = 6'd14,
  parameter logic [CTRL_W-1:0] DIV_CODE = 6'd15,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 16,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [1:0]        alu_op,
  input  logic [CTRL_W-1:0] func,
  input  logic [2:0]        branch_info,
  input  logic              jxx,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              out_valid,
  output logic              stall,
  output logic              mc_busy,
  output logic [CNT_W-1:0]  mc_count
);
  localparam int LW = $clog2((MUL_LAT > DIV_LAT ? MUL_LAT : DIV_LAT) + 1);
  localparam logic [0:0] IDLE = 1'b0, BUSY = 1'b1;
  logic [0:0] state;
  logic [LW-1:0] cnt, lat_m1;
  logic [CTRL_W-1:0] dec;
  logic is_mul, is_div;
  always_comb begin
    dec = (alu_op == 2'b11 && jxx) ? CTRL_W'(13)
        : branch_info[2] ? CTRL_W'(4'd9 + {2'b00, branch_info[1:0]})
        : alu_op == 2'b00 ? '0
        : alu_op == 2'b01 ? CTRL_W'(3)
        : alu_op == 2'b10 ? CTRL_W'(8)
        : func;
    is_mul = dec == MUL_CODE && MUL_LAT > 1;
    is_div = dec == DIV_CODE && DIV_LAT > 1;
    lat_m1 = is_mul ? LW'(MUL_LAT - 1) : LW'(DIV_LAT - 1);
  end
  assign stall = state == BUSY;
  assign mc_busy = state == BUSY;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      out_ctrl <= '0;
      out_valid <= 1'b0;
      mc_count <= '0;
    end else if (flush) begin
      state <= IDLE;
      cnt <= '0;
      out_ctrl <= '0;
      out_valid <= 1'b0;
    end else if (state == BUSY) begin
      cnt <= cnt - LW'(1);
      out_valid <= 1'b0;
      if (cnt == LW'(1)) begin
        state <= IDLE;
        out_valid <= 1'b1;
        mc_count <= mc_count + CNT_W'(1);
      end
    end else if (in_valid) begin
      out_ctrl <= dec;
      state <= (is_mul || is_div) ? BUSY : IDLE;
      cnt <= (is_mul || is_div) ? lat_m1 : '0;
      out_valid <= !(is_mul || is_div);
    end else begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: directed scoreboard bench for alu_ctrl_seq (default and MUL_LAT=1/CNT_W=2 instances)
module tb_alu_ctrl_seq;
  logic clk = 1'b0, reset = 1'b1, flush = 1'b0, in_valid = 1'b0, jxx = 1'b0;
  logic [1:0] alu_op = '0;
  logic [5:0] func = '0;
  logic [2:0] branch_info = '0;
  logic [5:0] out_ctrl;
  logic out_valid, stall, mc_busy;
  logic [7:0] mc_count;
  logic b_in_valid = 1'b0, b_jxx = 1'b0;
  logic [1:0] b_alu_op = '0;
  logic [5:0] b_func = '0;
  logic [2:0] b_bi = '0;
  logic [5:0] b_out_ctrl;
  logic b_out_valid, b_stall, b_mc_busy;
  logic [1:0] b_mc_count;
  int checks = 0, failures = 0;
  logic [5:0] exp_q[$];
  always #5 clk = ~clk;
  alu_ctrl_seq dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .alu_op(alu_op),
    .func(func), .branch_info(branch_info), .jxx(jxx), .out_ctrl(out_ctrl),
    .out_valid(out_valid), .stall(stall), .mc_busy(mc_busy), .mc_count(mc_count)
  );
  alu_ctrl_seq #(.MUL_LAT(1), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(b_in_valid), .alu_op(b_alu_op),
    .func(b_func), .branch_info(b_bi), .jxx(b_jxx), .out_ctrl(b_out_ctrl),
    .out_valid(b_out_valid), .stall(b_stall), .mc_busy(b_mc_busy), .mc_count(b_mc_count)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("sb_spurious_valid", 32'(out_valid), 0);
      else chk("sb_ctrl", 32'(out_ctrl), 32'(exp_q.pop_front()));
    end
  endtask
  task automatic op(input logic [1:0] a, input logic [5:0] f, input logic [2:0] bi, input logic j, input logic [5:0] e);
    in_valid = 1'b1;
    alu_op = a;
    func = f;
    branch_info = bi;
    jxx = j;
    exp_q.push_back(e);
  endtask
  task automatic idle();
    in_valid = 1'b0;
    alu_op = '0;
    func = '0;
    branch_info = '0;
    jxx = 1'b0;
  endtask
  initial begin
    tick();
    tick();
    chk("rst_ctrl", 32'(out_ctrl), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_busy", 32'(mc_busy), 0);
    chk("rst_count", 32'(mc_count), 0);
    reset = 1'b0;
    op(2'b00, 6'd0, 3'b000, 1'b0, 6'd0);
    tick();
    chk("add_valid", 32'(out_valid), 1);
    chk("add_stall", 32'(stall), 0);
    op(2'b01, 6'd0, 3'b000, 1'b0, 6'd3);
    tick();
    chk("or_valid", 32'(out_valid), 1);
    op(2'b10, 6'd0, 3'b000, 1'b0, 6'd8);
    tick();
    chk("lhi_valid", 32'(out_valid), 1);
    chk("lhi_stall", 32'(stall), 0);
    idle();
    tick();
    chk("idle_valid", 32'(out_valid), 0);
    chk("idle_hold", 32'(out_ctrl), 8);
    op(2'b00, 6'd0, 3'b101, 1'b0, 6'd10);
    tick();
    op(2'b11, 6'd0, 3'b110, 1'b1, 6'd13);
    tick();
    op(2'b11, 6'd5, 3'b000, 1'b0, 6'd5);
    tick();
    idle();
    tick();
    op(2'b11, 6'd14, 3'b000, 1'b0, 6'd14);
    tick();
    chk("mul_stall1", 32'(stall), 1);
    chk("mul_busy1", 32'(mc_busy), 1);
    chk("mul_valid1", 32'(out_valid), 0);
    idle();
    in_valid = 1'b1;
    alu_op = 2'b01;
    tick();
    chk("mul_stall2", 32'(stall), 1);
    chk("mul_ignore", 32'(out_ctrl), 14);
    idle();
    tick();
    chk("mul_done_stall", 32'(stall), 0);
    chk("mul_done_valid", 32'(out_valid), 1);
    chk("mul_count", 32'(mc_count), 1);
    op(2'b01, 6'd0, 3'b000, 1'b0, 6'd3);
    tick();
    chk("post_mc_valid", 32'(out_valid), 1);
    idle();
    tick();
    op(2'b11, 6'd15, 3'b000, 1'b0, 6'd15);
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("div_stall", 32'(stall), 1);
    end
    flush = 1'b1;
    in_valid = 1'b1;
    alu_op = 2'b01;
    exp_q.delete();
    tick();
    flush = 1'b0;
    idle();
    chk("flush_stall", 32'(stall), 0);
    chk("flush_valid", 32'(out_valid), 0);
    chk("flush_ctrl", 32'(out_ctrl), 0);
    chk("flush_count", 32'(mc_count), 1);
    repeat (20) tick();
    chk("flush_quiet", 32'(out_valid), 0);
    op(2'b11, 6'd14, 3'b000, 1'b0, 6'd14);
    tick();
    idle();
    tick();
    flush = 1'b1;
    exp_q.delete();
    tick();
    flush = 1'b0;
    chk("flush_cmpl_valid", 32'(out_valid), 0);
    chk("flush_cmpl_count", 32'(mc_count), 1);
    chk("flush_cmpl_busy", 32'(mc_busy), 0);
    op(2'b11, 6'd15, 3'b000, 1'b0, 6'd15);
    tick();
    idle();
    tick();
    tick();
    reset = 1'b1;
    exp_q.delete();
    tick();
    reset = 1'b0;
    chk("mrst_ctrl", 32'(out_ctrl), 0);
    chk("mrst_valid", 32'(out_valid), 0);
    chk("mrst_stall", 32'(stall), 0);
    chk("mrst_busy", 32'(mc_busy), 0);
    chk("mrst_count", 32'(mc_count), 0);
    op(2'b00, 6'd0, 3'b000, 1'b0, 6'd0);
    tick();
    chk("mrst_add_valid", 32'(out_valid), 1);
    idle();
    tick();
    b_in_valid = 1'b1;
    b_alu_op = 2'b11;
    b_func = 6'd14;
    tick();
    b_in_valid = 1'b0;
    chk("b_mul_valid", 32'(b_out_valid), 1);
    chk("b_mul_stall", 32'(b_stall), 0);
    chk("b_mul_ctrl", 32'(b_out_ctrl), 14);
    chk("b_mul_count", 32'(b_mc_count), 0);
    for (int n = 0; n < 5; n++) begin
      b_in_valid = 1'b1;
      b_func = 6'd15;
      tick();
      b_in_valid = 1'b0;
      chk("b_div_stall", 32'(b_stall), 1);
      for (int k = 0; k < 40 && b_out_valid !== 1'b1; k++) tick();
      chk("b_div_done", 32'(b_out_valid), 1);
    end
    chk("b_count_wrap", 32'(b_mc_count), 1);
    chk("sb_drain", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
